// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding,
// PC step and instruction width.
package if_fetch_pkg;

    localparam int          INSTR_W = 32;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } fetch_state_t;

    // Word-align a redirect address (clears the byte-offset bits).
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~(PC_STEP - 32'd1);
    endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch stage: one outstanding memory request, a one-entry hold
// buffer for responses that arrive while IF/ID is stalled, and flush/drop handling.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               is_stall,
    input  logic               is_flush,
    input  logic [31:0]        target_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [31:0]        imem_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    output logic               is_valid_out,
    output logic [31:0]        pc_out,
    output logic [INSTR_W-1:0] instr_out
);

    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;
    logic [31:0]        r_pc;
    logic [31:0]        r_req_pc;
    logic               r_hold_vld;
    logic [31:0]        r_hold_pc;
    logic [INSTR_W-1:0] r_hold_instr;

    logic               w_slot_free;
    logic               w_req_fire;
    logic               w_load;
    logic [31:0]        w_load_pc;
    logic [INSTR_W-1:0] w_load_instr;
    logic               w_capture;

    // The output slot can take a new word when empty or when it is being consumed.
    assign w_slot_free    = !is_valid_out || !is_stall;
    assign imem_req_valid = (r_state == S_REQ) && !is_flush && w_slot_free && !reset;
    assign imem_addr      = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // Next-state and output-load selection.
    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_load_pc    = r_req_pc;
        w_load_instr = imem_resp_data;
        w_capture    = 1'b0;
        case (r_state)
            S_REQ: begin
                if (is_flush) begin
                    w_state_nxt = S_REQ;
                end else if (w_req_fire) begin
                    w_state_nxt = S_WAIT;
                end else begin
                    w_state_nxt = S_REQ;
                end
            end
            S_WAIT: begin
                if (is_flush) begin
                    // A response arriving with the flush is simply ignored.
                    w_state_nxt = imem_resp_valid ? S_REQ : S_DROP;
                end else if (imem_resp_valid) begin
                    if (w_slot_free) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_HOLD: begin
                if (is_flush) begin
                    w_state_nxt = S_REQ;
                end else if (!is_stall && r_hold_vld) begin
                    w_load       = 1'b1;
                    w_load_pc    = r_hold_pc;
                    w_load_instr = r_hold_instr;
                    w_state_nxt  = S_REQ;
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_DROP: begin
                if (imem_resp_valid) begin
                    w_state_nxt = S_REQ;
                end else begin
                    w_state_nxt = S_DROP;
                end
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Fetch PC and in-flight request PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_req_pc <= 32'd0;
        end else if (is_flush) begin
            r_pc <= align_pc(target_pc);
        end else if (w_req_fire) begin
            r_req_pc <= r_pc;
            r_pc     <= r_pc + PC_STEP;
        end
    end

    // Presented instruction; a load wins over consumption of the previous word.
    always_ff @(posedge clk) begin
        if (reset) begin
            is_valid_out <= 1'b0;
            pc_out       <= 32'd0;
            instr_out    <= {INSTR_W{1'b0}};
        end else if (is_flush) begin
            is_valid_out <= 1'b0;
        end else if (w_load) begin
            is_valid_out <= 1'b1;
            pc_out       <= w_load_pc;
            instr_out    <= w_load_instr;
        end else if (!is_stall) begin
            is_valid_out <= 1'b0;
        end
    end

    // One-entry hold buffer for a response that met a stalled, full output slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_vld   <= 1'b0;
            r_hold_pc    <= 32'd0;
            r_hold_instr <= {INSTR_W{1'b0}};
        end else if (is_flush) begin
            r_hold_vld <= 1'b0;
        end else if (w_capture) begin
            r_hold_vld   <= 1'b1;
            r_hold_pc    <= r_req_pc;
            r_hold_instr <= imem_resp_data;
        end else if (w_load) begin
            r_hold_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Randomized scoreboard bench for if_fetch: a memory model answers requests,
// a reference PC stream predicts every presented instruction.
module tb_if_fetch;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset;
    logic        is_stall;
    logic        is_flush;
    logic [31:0] target_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        is_valid_out;
    logic [31:0] pc_out;
    logic [31:0] instr_out;

    if_fetch #(.RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .reset           (reset),
        .is_stall        (is_stall),
        .is_flush        (is_flush),
        .target_pc       (target_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .is_valid_out    (is_valid_out),
        .pc_out          (pc_out),
        .instr_out       (instr_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_consumed = 0;
    logic [31:0] model_pc = RST_PC;
    bit          prev_reset = 1'b0;
    bit          prev_hold  = 1'b0;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;

    // memory model state
    bit          mem_pending = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr;

    // stimulus knobs
    int          stall_pct = 0;
    int          flush_pct = 0;
    int          ready_pct = 100;
    int          lat_max   = 1;
    int          rst_pm    = 0;
    bit          flush_on_wait = 1'b0;
    bit          flush_on_resp = 1'b0;
    logic [31:0] dir_target;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, req);
    endtask

    task automatic drv(input bit rst);
        @(negedge clk);
        imem_resp_valid = 1'b0;
        if (mem_pending) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = memword(mem_addr);
                mem_pending     = 1'b0;
            end
        end
        reset = rst || ($urandom_range(999, 0) < rst_pm);
        if (reset) begin
            mem_pending     = 1'b0;
            imem_resp_valid = 1'b0;
        end
        is_stall  = $urandom_range(99, 0) < stall_pct;
        is_flush  = $urandom_range(99, 0) < flush_pct;
        target_pc = $urandom_range(1, 0) ? {24'hFF_FFFF, 8'($urandom)} : {20'h0, 12'($urandom)};
        if (flush_on_wait && mem_pending) begin
            is_flush = 1'b1; target_pc = dir_target; flush_on_wait = 1'b0;
        end
        if (flush_on_resp && imem_resp_valid) begin
            is_flush = 1'b1; target_pc = dir_target; flush_on_resp = 1'b0;
        end
        imem_req_ready = $urandom_range(99, 0) < ready_pct;
        #4;
        if (!reset && imem_req_valid && imem_req_ready) begin
            mem_pending = 1'b1;
            mem_addr    = imem_addr;
            mem_cnt     = $urandom_range(lat_max, 1);
        end
    endtask

    // Monitor / scoreboard: sampled mid-cycle, well away from the rising edge.
    always @(negedge clk) begin
        #3;
        if (prev_reset) begin
            check("rst_valid_out", 64'(is_valid_out), 64'd0);
            check("rst_pc_out",    64'(pc_out),       64'd0);
            check("rst_instr_out", 64'(instr_out),    64'd0);
            check("rst_imem_addr", 64'(imem_addr),    64'(RST_PC));
        end
        if (reset) begin
            check("req_valid_in_reset", 64'(imem_req_valid), 64'd0);
        end else begin
            if (imem_req_valid) begin
                check("req_gate", 64'({is_flush, is_valid_out && is_stall, mem_pending}), 64'd0);
                check("imem_addr", 64'(imem_addr), 64'(model_pc));
            end
            if (prev_hold) begin
                check("hold_valid", 64'(is_valid_out), 64'd1);
                check("hold_pc",    64'(pc_out),       64'(hold_pc));
                check("hold_instr", 64'(instr_out),    64'(hold_instr));
            end
            if (is_valid_out) begin
                check("valid_has_expected", 64'(sb.size() != 0), 64'd1);
                if (!is_stall && !is_flush && sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("pc_out",    64'(pc_out),    64'(mon_e.pc));
                    check("instr_out", 64'(instr_out), 64'(mon_e.instr));
                    n_consumed++;
                end
            end
        end
        if (reset) begin
            sb.delete();
            model_pc = RST_PC;
        end else if (is_flush) begin
            sb.delete();
            model_pc = {target_pc[31:2], 2'b00};
        end else if (imem_req_valid && imem_req_ready) begin
            sb.push_back('{model_pc, memword(model_pc)});
            model_pc = model_pc + 32'd4;
        end
        prev_reset = reset;
        prev_hold  = is_valid_out && is_stall && !is_flush && !reset;
        hold_pc    = pc_out;
        hold_instr = instr_out;
    end

    initial begin
        int c0;
        reset = 1'b1; is_stall = 1'b0; is_flush = 1'b0; target_pc = 32'd0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'd0;
        repeat (3) drv(1'b1);

        // zero-wait stream: one instruction every two cycles, across the PC wrap
        stall_pct = 0; flush_pct = 0; ready_pct = 100; lat_max = 1;
        repeat (4) drv(1'b0);
        c0 = n_consumed;
        repeat (10) drv(1'b0);
        check("throughput_10cyc", 64'(n_consumed - c0), 64'd5);

        // stall across a response, then release
        stall_pct = 100; repeat (3) drv(1'b0);
        stall_pct = 0;   repeat (6) drv(1'b0);

        // memory not ready for 5 cycles
        ready_pct = 0;   repeat (5) drv(1'b0);
        ready_pct = 100; repeat (4) drv(1'b0);

        // flush while waiting on a slow response
        lat_max = 3; dir_target = 32'h0000_0100; flush_on_wait = 1'b1;
        repeat (12) drv(1'b0);

        // flush coinciding with a response, misaligned target
        lat_max = 1; dir_target = 32'h0000_0203; flush_on_resp = 1'b1;
        repeat (8) drv(1'b0);

        // randomized traffic
        stall_pct = 30; flush_pct = 3; ready_pct = 70; lat_max = 4; rst_pm = 3;
        repeat (1500) drv(1'b0);

        // drain: no new requests, let everything in flight complete
        stall_pct = 0; flush_pct = 0; ready_pct = 0; rst_pm = 0;
        for (int i = 0; i < 200 && (sb.size() != 0 || is_valid_out || mem_pending); i++) drv(1'b0);
        check("drain_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
